// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritized
// write ports, optional zero register and write-to-read bypass, post-reset clear sweep.

module reg_file_mp_rd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                   busy,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic [1:0]             wr_en,
  input  logic [1:0][ADDR_W-1:0] wr_addr,
  input  logic [1:0][DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]      data
);
  // Port 1 is checked first so the bypass agrees with the write priority.
  always_comb begin
    data = mem_data;
    if (busy)
      data = '0;
    else if (ZERO_REG && addr == '0)
      data = '0;
    else if (BYPASS && wr_en[1] && wr_addr[1] == addr)
      data = wr_data[1];
    else if (BYPASS && wr_en[0] && wr_addr[0] == addr)
      data = wr_data[0];
  end
endmodule

module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                       SYS_clk,
  input  logic                       SYS_reset,
  input  logic [NUM_RD*ADDR_W-1:0]   RF_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   RF_rd_data,
  input  logic [1:0]                 RF_wr_en,
  input  logic [2*ADDR_W-1:0]        RF_wr_addr,
  input  logic [2*DATA_W-1:0]        RF_wr_data,
  output logic                       RF_busy,
  output logic                       RF_wr_conflict,
  output logic                       RF_wr_drop
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                        state, state_nxt;
  logic [ADDR_W-1:0]             clr_cnt;
  logic [DATA_W-1:0]             mem [DEPTH];
  logic [1:0]                    wr_ok;
  logic                          conflict_nxt, drop_nxt;
  logic [1:0][ADDR_W-1:0]        wa;
  logic [1:0][DATA_W-1:0]        wd;
  logic [NUM_RD-1:0][ADDR_W-1:0] ra;
  logic [NUM_RD-1:0][DATA_W-1:0] rd, rd_mem;

  assign wa         = RF_wr_addr;
  assign wd         = RF_wr_data;
  assign ra         = RF_rd_addr;
  assign RF_rd_data = rd;

  always_comb begin
    state_nxt    = state;
    wr_ok        = '0;
    conflict_nxt = 1'b0;
    drop_nxt     = 1'b0;
    case (state)
      CLEAR: begin
        drop_nxt = |RF_wr_en;
        if (&clr_cnt) state_nxt = READY;
      end
      READY: begin
        for (int p = 0; p < 2; p++)
          wr_ok[p] = RF_wr_en[p] && !(ZERO_REG && wa[p] == '0);
        conflict_nxt = (&wr_ok) && (wa[0] == wa[1]);
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state          <= CLEAR;
      clr_cnt        <= '0;
      RF_busy        <= 1'b1;
      RF_wr_conflict <= 1'b0;
      RF_wr_drop     <= 1'b0;
    end else begin
      state          <= state_nxt;
      RF_busy        <= (state_nxt == CLEAR);
      RF_wr_conflict <= conflict_nxt;
      RF_wr_drop     <= drop_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Storage is left alone on reset edges; the sweep zeroes it afterwards.
  // Port 1 is written last so it wins on an address collision.
  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      if (state == CLEAR) mem[clr_cnt] <= '0;
      for (int p = 0; p < 2; p++)
        if (wr_ok[p]) mem[wa[p]] <= wd[p];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_mem[i] = mem[ra[i]];
    reg_file_mp_rd #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .busy(RF_busy), .addr(ra[i]), .mem_data(rd_mem[i]),
      .wr_en(RF_wr_en), .wr_addr(wa), .wr_data(wd), .data(rd[i])
    );
  end
endmodule
